mem_arbiter: RTL

//  Shares one port of the dual-port byte-enabled RAM between two requesters
//  (r0 = CPU load/store unit, r1 = GOL frame scanner/loader). Arbitrates,

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response signals of the two requesters plus the shared RAM port
// for mem_arbiter; slave = arbiter side, master = requesters and RAM side.
interface mem_arbiter_if #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int BYTES         = 4
);
   localparam int AW = ADDRESS_WIDTH + 2;

   logic                     r0_valid, r0_ready, r0_we;
   logic [AW-1:0]            r0_addr;
   logic [1:0]               r0_size;
   logic [DATA_WIDTH-1:0]    r0_wdata;
   logic                     r0_rsp_valid, r0_rsp_err;
   logic [DATA_WIDTH-1:0]    r0_rsp_rdata;

   logic                     r1_valid, r1_ready, r1_we;
   logic [AW-1:0]            r1_addr;
   logic [1:0]               r1_size;
   logic [DATA_WIDTH-1:0]    r1_wdata;
   logic                     r1_rsp_valid, r1_rsp_err;
   logic [DATA_WIDTH-1:0]    r1_rsp_rdata;

   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [BYTES-1:0]         mem_be;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   modport slave (
      input  r0_valid, r0_we, r0_addr, r0_size, r0_wdata,
      output r0_ready, r0_rsp_valid, r0_rsp_err, r0_rsp_rdata,
      input  r1_valid, r1_we, r1_addr, r1_size, r1_wdata,
      output r1_ready, r1_rsp_valid, r1_rsp_err, r1_rsp_rdata,
      output mem_addr, mem_be, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output r0_valid, r0_we, r0_addr, r0_size, r0_wdata,
      input  r0_ready, r0_rsp_valid, r0_rsp_err, r0_rsp_rdata,
      output r1_valid, r1_we, r1_addr, r1_size, r1_wdata,
      input  r1_ready, r1_rsp_valid, r1_rsp_err, r1_rsp_rdata,
      input  mem_addr, mem_be, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one byte-enabled RAM port: IDLE -> ACCESS -> RESP.
// Define MEM_ARB_FIXED_PRIO_EN for fixed r0 priority instead of round-robin.
module mem_arbiter #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int BYTE_WIDTH    = 8,
   parameter int BYTES         = 4,
   parameter int DATA_WIDTH    = BYTE_WIDTH * BYTES
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int AW = ADDRESS_WIDTH + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t                   state_q, state_d;
   logic                     grant_q, grant_d;
   logic                     we_q, we_d;
   logic                     err_q, err_d;
   logic [1:0]               off_q, off_d;
   logic [1:0]               size_q, size_d;
   logic [1:0]               rsp_valid_q, rsp_valid_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [BYTES-1:0]         mem_be_q, mem_be_d;
   logic                     mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic                     last_grant_q, last_grant_d;
`endif

   logic                     sel, req_valid, req_we, req_err;
   logic [AW-1:0]            req_addr;
   logic [1:0]               req_size;
   logic [DATA_WIDTH-1:0]    req_wdata, req_lanes;
   logic [BYTES-1:0]         req_be;
   logic [DATA_WIDTH-1:0]    load_shifted, load_mask, rsp_rdata;

   // sel picks the requester that would be accepted this cycle.
   always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      sel = !bus.r0_valid && bus.r1_valid;
`else
      sel = (bus.r0_valid && bus.r1_valid) ? !last_grant_q : bus.r1_valid;
`endif
   end

   assign bus.r0_ready = (state_q == IDLE) && !sel && !reset;
   assign bus.r1_ready = (state_q == IDLE) &&  sel && !reset;

   assign req_valid = sel ? bus.r1_valid : bus.r0_valid;
   assign req_we    = sel ? bus.r1_we    : bus.r0_we;
   assign req_addr  = sel ? bus.r1_addr  : bus.r0_addr;
   assign req_size  = sel ? bus.r1_size  : bus.r0_size;
   assign req_wdata = sel ? bus.r1_wdata : bus.r0_wdata;

   // Narrow stores are replicated across lanes; byte enables pick the target.
   always_comb begin
      req_err   = 1'b0;
      req_be    = '0;
      req_lanes = req_wdata;
      case (req_size)
         2'd0: begin
            req_be    = {{(BYTES-1){1'b0}}, 1'b1} << req_addr[1:0];
            req_lanes = {BYTES{req_wdata[BYTE_WIDTH-1:0]}};
         end
         2'd1: begin
            req_be    = {{(BYTES-2){1'b0}}, 2'b11} << req_addr[1:0];
            req_err   = req_addr[0];
            req_lanes = {(BYTES/2){req_wdata[2*BYTE_WIDTH-1:0]}};
         end
         2'd2: begin
            req_be  = '1;
            req_err = |req_addr[1:0];
         end
         default: req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      we_d        = we_q;
      err_d       = err_q;
      off_d       = off_q;
      size_d      = size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_be_d    = '0;
      rsp_valid_d = 2'b00;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d     = ACCESS;
               grant_d     = sel;
               we_d        = req_we;
               err_d       = req_err;
               off_d       = req_addr[1:0];
               size_d      = req_size;
               mem_addr_d  = req_addr[AW-1:2];
               mem_wdata_d = req_lanes;
               mem_we_d    = req_we && !req_err;
               mem_be_d    = req_err ? '0 : req_be;
`ifndef MEM_ARB_FIXED_PRIO_EN
               last_grant_d = sel;
`endif
            end
         end
         ACCESS: begin
            state_d              = RESP;
            rsp_valid_d[grant_q] = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         off_q        <= 2'b00;
         size_q       <= 2'b00;
         rsp_valid_q  <= 2'b00;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         err_q        <= err_d;
         off_q        <= off_d;
         size_q       <= size_d;
         rsp_valid_q  <= rsp_valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;

   // RAM data arrives during RESP, so the load alignment stays combinational.
   assign load_shifted = bus.mem_rdata >> (BYTE_WIDTH * off_q);

   always_comb begin
      case (size_q)
         2'd0:    load_mask = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, {BYTE_WIDTH{1'b1}}};
         2'd1:    load_mask = {{(DATA_WIDTH-2*BYTE_WIDTH){1'b0}}, {(2*BYTE_WIDTH){1'b1}}};
         default: load_mask = '1;
      endcase
   end

   assign rsp_rdata = (we_q || err_q) ? '0 : (load_shifted & load_mask);

   assign bus.r0_rsp_valid = rsp_valid_q[0];
   assign bus.r1_rsp_valid = rsp_valid_q[1];
   assign bus.r0_rsp_err   = rsp_valid_q[0] && err_q;
   assign bus.r1_rsp_err   = rsp_valid_q[1] && err_q;
   assign bus.r0_rsp_rdata = rsp_valid_q[0] ? rsp_rdata : '0;
   assign bus.r1_rsp_rdata = rsp_valid_q[1] ? rsp_rdata : '0;
endmodule
